// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NRD combinational read ports, x0 hardwired to zero,
// and a one-register-per-cycle clear sweep. Define REGFILE_MP_BYPASS_EN for write-first reads.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [XLEN-1:0]   wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [XLEN-1:0]   wd1,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*XLEN-1:0] rd
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mem_q [NREGS];
    logic            wr0_en, wr1_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == CLEAR);
    assign wr0_en = we0 && !busy && (wa0 != '0);
    assign wr1_en = we1 && !busy && (wa1 != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Port 1 is written last so it wins on a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                mem_q[cnt_q] <= '0;
            end else begin
                if (wr0_en) mem_q[wa0] <= wd0;
                if (wr1_en) mem_q[wa1] <= wd1;
            end
        end
    end

    always_comb begin
        logic [AW-1:0] addr;
        rd   = '0;
        addr = '0;
        for (int i = 0; i < NRD; i++) begin
            addr = ra[i*AW +: AW];
            if (!busy && (addr != '0)) begin
`ifdef REGFILE_MP_BYPASS_EN
                if (wr1_en && (wa1 == addr)) begin
                    rd[i*XLEN +: XLEN] = wd1;
                end else if (wr0_en && (wa0 == addr)) begin
                    rd[i*XLEN +: XLEN] = wd0;
                end else begin
                    rd[i*XLEN +: XLEN] = mem_q[addr];
                end
`else
                rd[i*XLEN +: XLEN] = mem_q[addr];
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 32x32/2-port instance and a 16-entry/3-port instance.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic        rst, clr_req, busy, we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [9:0]  ra;
    logic [63:0] rd;

    logic        b_rst, b_clr_req, b_busy, b_we0, b_we1;
    logic [3:0]  b_wa0, b_wa1;
    logic [31:0] b_wd0, b_wd1;
    logic [11:0] b_ra;
    logic [95:0] b_rd;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2)) u_dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd)
    );

    regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3)) u_dut16 (
        .clk(clk), .rst(b_rst), .clr_req(b_clr_req), .busy(b_busy),
        .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
        .ra(b_ra), .rd(b_rd)
    );

    // kind: 0 = rd of u_dut, 1 = busy of u_dut, 2 = rd of u_dut16, 3 = busy of u_dut16
    int          q_kind[$];
    int          q_port[$];
    logic [31:0] q_val[$];
    string       q_name[$];
    int          total = 0;
    int          bad   = 0;

    task automatic push(input int kind, input int port, input logic [31:0] v, input string n);
        q_kind.push_back(kind);
        q_port.push_back(port);
        q_val.push_back(v);
        q_name.push_back(n);
    endtask

    always @(negedge clk) begin
        int          k, p;
        logic [31:0] e, a;
        string       n;
        while (q_kind.size() > 0) begin
            k = q_kind.pop_front();
            p = q_port.pop_front();
            e = q_val.pop_front();
            n = q_name.pop_front();
            case (k)
                0:       a = rd[p*32 +: 32];
                1:       a = {31'b0, busy};
                2:       a = b_rd[p*32 +: 32];
                default: a = {31'b0, b_busy};
            endcase
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: port %0d got %h expected %h at %0t", n, p, a, e, $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
    endtask

    task automatic idle_b();
        b_we0 = 1'b0; b_we1 = 1'b0; b_clr_req = 1'b0;
    endtask

    // Expects busy high for n observed cycles, then queues the busy-low check.
    task automatic sweep_check(input int kind, input int n, input string name);
        for (int k = 0; k < n; k++) begin
            push(kind, 0, 32'd1, name);
            step();
        end
        push(kind, 0, 32'd0, {name, "_end"});
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0; we0 = 1'b0; we1 = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;
        b_rst = 1'b1; b_clr_req = 1'b0; b_we0 = 1'b0; b_we1 = 1'b0;
        b_wa0 = '0; b_wa1 = '0; b_wd0 = '0; b_wd1 = '0; b_ra = '0;

        step();
        ra = {5'd17, 5'd5};
        push(0, 0, 32'd0, "reset_rd0");
        push(0, 1, 32'd0, "reset_rd1");
        push(1, 0, 32'd1, "reset_busy");
        step();
        rst = 1'b0;
        sweep_check(1, 32, "sweep_after_rst");
        step();

        for (int a = 0; a < 32; a++) begin
            ra[4:0] = 5'(a);
            ra[9:5] = 5'(31 - a);
            push(0, 0, 32'd0, "post_sweep_zero");
            push(0, 1, 32'd0, "post_sweep_zero");
            step();
        end

        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        step();
        idle_a();
        ra[4:0] = 5'd5;
        push(0, 0, 32'hDEADBEEF, "write_read");
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h1234;
        ra[9:5] = 5'd0;
        push(0, 1, 32'd0, "x0_no_bypass");
        step();
        idle_a();
        push(0, 1, 32'd0, "x0_write_ignored");
        step();

        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        step();
        idle_a();
        ra[4:0] = 5'd7;
        push(0, 0, 32'h22, "same_addr_port1_wins");
        step();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAA;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hBB;
        step();
        idle_a();
        ra = {5'd4, 5'd3};
        push(0, 0, 32'hAA, "dual_write_p0");
        push(0, 1, 32'hBB, "dual_write_p1");
        step();

        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h55;
        step();
        ra = {5'd9, 5'd9};
        wd0 = 32'h66;
        push(0, 0, BYP ? 32'h66 : 32'h55, "bypass_single");
        step();
        idle_a();
        push(0, 0, 32'h66, "after_bypass_write");
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h77;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h88;
        push(0, 1, BYP ? 32'h88 : 32'h66, "bypass_port1_prio");
        step();
        idle_a();
        push(0, 0, 32'h88, "after_dual_same");
        step();

        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h99;
        step();
        idle_a();
        clr_req = 1'b1;
        ra[4:0] = 5'd2;
        push(0, 0, 32'h99, "pre_clear");
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            push(1, 0, 32'd1, "clr_sweep_busy");
            if (k == 0) begin
                ra[4:0] = 5'd5;
                push(0, 0, 32'd0, "rd_forced_busy");
            end
            if (k == 3) begin
                we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h77;
                ra[9:5] = 5'd2;
                push(0, 1, 32'd0, "no_bypass_busy");
            end
            if (k == 10) clr_req = 1'b1;
            step();
            idle_a();
        end
        push(1, 0, 32'd0, "clr_sweep_end");
        ra = {5'd5, 5'd2};
        push(0, 0, 32'd0, "dropped_write");
        push(0, 1, 32'd0, "cleared_reg");
        step();

        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            push(1, 0, 32'd1, "pre_rst_busy");
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        sweep_check(1, 32, "rst_mid_sweep");
        step();

        b_rst = 1'b0;
        sweep_check(3, 16, "b_sweep_len");
        step();
        b_we0 = 1'b1; b_wa0 = 4'd3;  b_wd0 = 32'h333;
        b_we1 = 1'b1; b_wa1 = 4'd15; b_wd1 = 32'hF0F;
        step();
        idle_b();
        b_ra = {4'd0, 4'd15, 4'd3};
        push(2, 0, 32'h333, "b_rd0");
        push(2, 1, 32'hF0F, "b_rd1");
        push(2, 2, 32'd0, "b_rd2_x0");
        step();
        b_clr_req = 1'b1;
        step();
        b_clr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            push(3, 0, 32'd1, "b_pre_rst_busy");
            step();
        end
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        sweep_check(3, 16, "b_rst_mid_sweep");
        push(2, 0, 32'd0, "b_cleared");
        push(2, 1, 32'd0, "b_cleared");
        step();
        step();

        if (q_kind.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", q_kind.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of 2, >= 4; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2: read-port count, 1..4.
REQ-004 SHALL have port clk  in  1: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1: synchronous reset, active-high.
REQ-006 SHALL have port clr_req  in  1: request a full register clear.
REQ-007 SHALL have port busy  out  1: high while a clear sweep is in progress.
REQ-008 SHALL have port we0  in  1: write enable, write port 0.
REQ-009 SHALL have port wa0  in  AW: write address, port 0.
REQ-010 SHALL have port wd0  in  XLEN: write data, port 0.
REQ-011 SHALL have ports we1 / wa1 / wd1  in  1 / AW / XLEN: write port 1, same meaning as port 0.
REQ-012 SHALL have port ra  in  NRD*AW: read addresses; port i occupies bits [i*AW +: AW].
REQ-013 SHALL have port rd  out  NRD*XLEN: read data; port i occupies bits [i*XLEN +: XLEN].

Function
REQ-014 SHALL drive rd[i] combinationally from ra[i], with no clock latency.
REQ-015 SHALL return 0 on any read port whose address is 0 (x0 hardwired).
REQ-016 SHALL commit a write at the rising edge when weN=1, busy=0 and waN!=0.
REQ-017 SHALL ignore writes to address 0 with no side effect.
REQ-018 SHALL, when both ports write the same nonzero address in one cycle, store wd1 (port 1 priority).
REQ-019 SHALL commit both writes when the two ports write different addresses in one cycle.
REQ-020 SHALL implement a two-state FSM, IDLE and CLEAR, with an AW-bit sweep counter cnt.
REQ-021 SHALL transition IDLE->CLEAR on clr_req=1 and set cnt=0.
REQ-022 SHALL, in CLEAR, write 0 to register cnt and increment cnt every cycle.
REQ-023 SHALL transition CLEAR->IDLE in the cycle after the write at cnt=NREGS-1; a sweep takes exactly NREGS cycles.
REQ-024 SHALL hold busy=1 exactly while in CLEAR.
REQ-025 SHALL ignore clr_req while in CLEAR (no restart).
REQ-026 SHALL drop we0/we1 while busy=1; dropped writes are lost and never replayed.
REQ-027 SHALL force all rd ports to 0 while busy=1.

Reset
REQ-028 SHALL, with rst=1 at an edge, enter CLEAR with cnt=0 and busy=1, so a full NREGS-cycle sweep follows reset deassertion.
REQ-029 SHALL, when rst asserts mid-sweep, restart the sweep from cnt=0.
REQ-030 SHALL give rst priority over clr_req and over both write ports.
REQ-031 SHALL have reset values busy=1 and rd=0 for all ports.

Configuration
REQ-032 SHALL, with macro REGFILE_MP_BYPASS_EN defined, forward same-cycle write data to a read port whose nonzero address matches an enabled write, using port 1 over port 0 (write-first).
REQ-033 SHALL, without REGFILE_MP_BYPASS_EN, return the pre-edge stored value on address match (read-first).
REQ-034 SHALL never bypass while busy=1 or for address 0, whether or not the macro is defined.

Verification
REQ-035 SHALL cover: rst for 1 cycle, then release -> busy=1 for exactly 32 cycles, then 0, and every ra reads 0.
REQ-036 SHALL cover: we0=1, wa0=5, wd0=0xDEADBEEF; next cycle ra[0]=5 -> rd[0]=0xDEADBEEF; we1=1, wa1=0, wd1=0x1234; then ra[1]=0 -> rd[1]=0.
REQ-037 SHALL cover: same cycle, we0/wa0=7/wd0=0x11 and we1/wa1=7/wd1=0x22 -> reg 7 reads 0x22; separately, wa0=3/0xAA with wa1=4/0xBB -> both stored.
REQ-038 SHALL cover: reg 9=0x55, then ra[0]=9 with we0=1, wa0=9, wd0=0x66 in one cycle -> rd[0]=0x66 with REGFILE_MP_BYPASS_EN defined, 0x55 without.
REQ-039 SHALL cover: clr_req pulse, then we0 to reg 2 in sweep cycle 3 -> write dropped, reg 2=0 after the sweep; a second clr_req mid-sweep leaves the length at 32 cycles.
REQ-040 SHALL cover: rst asserted at sweep cycle 10 -> sweep restarts, busy stays 1 for 32 more cycles after release; NREGS=16, NRD=3 rerun of these scenarios -> sweep length 16.
